// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its access checker.
package dmem_arbiter_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Width of the address held in a latched command.
    localparam int unsigned CMD_ADDR_W = 32;

    typedef enum logic [1:0] {StIdle, StGrant, StAccess, StResp} arb_state_t;

    typedef enum logic {PortC, PortD} port_id_t;

    typedef struct packed {
        logic                  we;
        logic [2:0]            typ;
        logic [CMD_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle: one instance per port (CPU or debug/loader).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, req_type, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, req_type, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter_align_chk.sv
// Combinational legality check of a memory command: width code, store/unsigned
// combination, natural alignment and address range against a DEPTH-word memory.
module dmem_arbiter_align_chk
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 101,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [2:0]        type_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

    logic bad_type;
    logic misalign;

    always_comb begin
        bad_type = 1'b1;
        misalign = 1'b0;
        case (type_i)
            MEM_B, MEM_BU: bad_type = 1'b0;
            MEM_H, MEM_HU: begin
                bad_type = 1'b0;
                misalign = addr_i[0];
            end
            MEM_W: begin
                bad_type = 1'b0;
                misalign = |addr_i[1:0];
            end
            default: bad_type = 1'b1;
        endcase
        // Unsigned widths exist for loads only.
        err_o = bad_type | (we_i & type_i[2]) | misalign | (addr_i >= LIMIT);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing the single-port data memory between the CPU port
// (C) and the debug/loader port (D); one registered request -> one memory cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 101,
    parameter int unsigned ADDR_W = CMD_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     c_if,
    dmem_arbiter_if.slave     d_if,
    output logic              d_wr_en,
    output logic [2:0]        store_type,
    output logic [2:0]        load_type,
    output logic [ADDR_W-1:0] dAddr,
    output logic [31:0]       dWdata,
    input  logic [31:0]       dRdata
);

    arb_state_t  state_q;
    mem_cmd_t    cmd_q;
    port_id_t    port_q;
    port_id_t    last_q;
    logic        err_q;
    logic        c_ack_q, d_ack_q;
    logic        c_err_q, d_err_q;
    logic [31:0] c_rdata_q, d_rdata_q;
    logic        chk_err;
    logic        pick_c;

    // C wins unless D also requests and C was the port served last.
    assign pick_c = c_if.req & (~d_if.req | (last_q == PortD));

    dmem_arbiter_align_chk #(
        .DEPTH  (DEPTH),
        .ADDR_W (CMD_ADDR_W)
    ) u_align_chk (
        .type_i (cmd_q.typ),
        .we_i   (cmd_q.we),
        .addr_i (cmd_q.addr),
        .err_o  (chk_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            port_q    <= PortC;
            last_q    <= PortD;
            err_q     <= 1'b0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (c_if.req || d_if.req) begin
                        if (pick_c) begin
                            port_q <= PortC;
                            cmd_q  <= '{we: c_if.we, typ: c_if.req_type,
                                        addr: CMD_ADDR_W'(c_if.addr), wdata: c_if.wdata};
                        end else begin
                            port_q <= PortD;
                            cmd_q  <= '{we: d_if.we, typ: d_if.req_type,
                                        addr: CMD_ADDR_W'(d_if.addr), wdata: d_if.wdata};
                        end
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    err_q   <= chk_err;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (port_q == PortC) begin
                        if (!cmd_q.we && !err_q) c_rdata_q <= dRdata;
                        c_ack_q <= 1'b1;
                        c_err_q <= err_q;
                    end else begin
                        if (!cmd_q.we && !err_q) d_rdata_q <= dRdata;
                        d_ack_q <= 1'b1;
                        d_err_q <= err_q;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    last_q  <= port_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory side is parked at a neutral word access whenever it is not ours.
    always_comb begin
        d_wr_en    = 1'b0;
        dAddr      = '0;
        dWdata     = '0;
        load_type  = MEM_W;
        store_type = MEM_W;
        if (state_q == StAccess) begin
            d_wr_en    = cmd_q.we & ~err_q & ~reset;
            dAddr      = ADDR_W'(cmd_q.addr);
            dWdata     = cmd_q.wdata;
            load_type  = cmd_q.typ;
            store_type = cmd_q.typ;
        end
    end

    assign c_if.ack   = c_ack_q;
    assign c_if.err   = c_err_q;
    assign c_if.rdata = c_rdata_q;
    assign d_if.ack   = d_ack_q;
    assign d_if.err   = d_err_q;
    assign d_if.rdata = d_rdata_q;

    // The granted requester must keep req high through its ack cycle.
    c_req_held_a: assert property (@(posedge clk) disable iff (reset)
        (state_q != StIdle && port_q == PortC) |-> c_if.req);
    d_req_held_a: assert property (@(posedge clk) disable iff (reset)
        (state_q != StIdle && port_q == PortD) |-> d_if.req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions on both ports against a
// behavioural 101-word data memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned DEPTH = 101;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_wr_en;
    logic [2:0]  store_type, load_type;
    logic [31:0] dAddr, dWdata, dRdata;
    logic [31:0] mem [0:DEPTH-1];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int wr0;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) c_if ();
    dmem_arbiter_if #(.ADDR_W(32)) d_if ();

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .c_if       (c_if),
        .d_if       (d_if),
        .d_wr_en    (d_wr_en),
        .store_type (store_type),
        .load_type  (load_type),
        .dAddr      (dAddr),
        .dWdata     (dWdata),
        .dRdata     (dRdata)
    );

    function automatic logic [31:0] mem_read(logic [31:0] a, logic [2:0] t);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = (a[31:2] < DEPTH) ? mem[a[31:2]] : 32'h0;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always_comb dRdata = mem_read(dAddr, load_type);

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        mem[0]   <= 32'h8001_7F00;
        mem[4]   <= 32'hDEAD_BEEF;
        mem[16]  <= 32'h5555_AAAA;
        mem[100] <= 32'hCAFE_F00D;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (d_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (dAddr[31:2] < DEPTH) begin
                case (store_type)
                    3'b000:  mem[dAddr[31:2]][8*dAddr[1:0] +: 8] <= dWdata[7:0];
                    3'b001:  mem[dAddr[31:2]][16*dAddr[1] +: 16] <= dWdata[15:0];
                    default: mem[dAddr[31:2]] <= dWdata;
                endcase
            end
        end
    end

    function automatic void exp_push(bit p, bit e, logic [31:0] r);
        exp_t x;
        x.port  = p;
        x.err   = e;
        x.rdata = r;
        exp_q.push_back(x);
    endfunction

    function automatic void sb_check(bit p, logic e, logic [31:0] r);
        exp_t x;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ack: port %0d acked (err=%0b rdata=%h), none required",
                     p, e, r);
        end else begin
            x = exp_q.pop_front();
            if (x.port != p || e !== x.err || r !== x.rdata) begin
                fails++;
                $display("FAIL ack_check: got port %0d err %0b rdata %h, required port %0d err %0b rdata %h",
                         p, e, r, x.port, x.err, x.rdata);
            end
        end
    endfunction

    // Monitor: every ack is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (c_if.ack) sb_check(1'b0, c_if.err, c_if.rdata);
        if (d_if.ack) sb_check(1'b1, d_if.err, d_if.rdata);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Runs one request on port p; called and returns just after a rising edge.
    task automatic txn(input bit p, input bit we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat);
        int start;
        bit got;
        if (!p) begin
            c_if.we = we; c_if.req_type = t; c_if.addr = a; c_if.wdata = wd; c_if.req = 1'b1;
        end else begin
            d_if.we = we; d_if.req_type = t; d_if.addr = a; d_if.wdata = wd; d_if.req = 1'b1;
        end
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((!p && c_if.ack) || (p && d_if.ack)) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout: port %0d addr %h got no ack, required ack within 40 cycles",
                     p, a);
        end else if (exp_lat >= 0) begin
            check($sformatf("latency_p%0d_%h", p, a), cyc - start, exp_lat);
        end
        @(posedge clk);
        #1;
        if (!p) c_if.req = 1'b0;
        else d_if.req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        c_if.req = 0; c_if.we = 0; c_if.req_type = 0; c_if.addr = 0; c_if.wdata = 0;
        d_if.req = 0; d_if.we = 0; d_if.req_type = 0; d_if.addr = 0; d_if.wdata = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_c_ack", c_if.ack, 0);
        check("rst_d_ack", d_if.ack, 0);
        check("rst_c_err", c_if.err, 0);
        check("rst_c_rdata", c_if.rdata, 0);
        check("rst_d_rdata", d_if.rdata, 0);
        check("rst_wr_en", d_wr_en, 0);
        check("rst_daddr", dAddr, 0);
        check("rst_dwdata", dWdata, 0);
        check("rst_load_type", load_type, 3'b010);
        check("rst_store_type", store_type, 3'b010);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Plain CPU word load.
        exp_push(0, 0, 32'hDEAD_BEEF);
        txn(0, 0, 3'b010, 32'h10, 0, 3);

        // Simultaneous stores right after reset: C first, D four cycles later.
        do_reset();
        wr0 = wr_cnt;
        exp_push(0, 0, 32'h0);
        exp_push(1, 0, 32'h0);
        fork
            txn(0, 1, 3'b010, 32'h20, 32'h11, 3);
            txn(1, 1, 3'b010, 32'h24, 32'h22, 7);
        join
        check("mem8", mem[8], 32'h11);
        check("mem9", mem[9], 32'h22);
        check("wr_cnt_two_stores", wr_cnt - wr0, 2);

        // Byte store then signed and unsigned byte loads on the debug port.
        exp_push(1, 0, 32'h0);
        txn(1, 1, 3'b000, 32'h31, 32'hA5, 3);
        check("mem12_sb", mem[12], 32'h0000_A500);
        exp_push(1, 0, 32'hFFFF_FFA5);
        txn(1, 0, 3'b000, 32'h31, 0, 3);
        exp_push(1, 0, 32'h0000_00A5);
        txn(1, 0, 3'b100, 32'h31, 0, 3);

        // Alignment, range and type checks on the CPU port.
        exp_push(0, 0, 32'hFFFF_8001);
        txn(0, 0, 3'b001, 32'h02, 0, 3);
        wr0 = wr_cnt;
        exp_push(0, 1, 32'hFFFF_8001);
        txn(0, 0, 3'b010, 32'h06, 0, 3);
        exp_push(0, 0, 32'hCAFE_F00D);
        txn(0, 0, 3'b010, 32'h190, 0, 3);
        exp_push(0, 1, 32'hCAFE_F00D);
        txn(0, 1, 3'b010, 32'h194, 32'h1, 3);
        exp_push(0, 1, 32'hCAFE_F00D);
        txn(0, 1, 3'b100, 32'h44, 32'h77, 3);
        check("no_write_on_err", wr_cnt - wr0, 0);
        check("mem17_untouched", mem[17], 32'h0);

        // Reset landing in the ACCESS cycle of a store abandons it.
        wr0 = wr_cnt;
        c_if.we = 1; c_if.req_type = 3'b010; c_if.addr = 32'h40; c_if.wdata = 32'h1234_5678;
        c_if.req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        c_if.req = 1'b0;
        @(negedge clk);
        check("abort_daddr_in_access", dAddr, 32'h40);
        check("abort_wr_gated", d_wr_en, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_mem16", mem[16], 32'h5555_AAAA);
        check("abort_c_rdata", c_if.rdata, 0);
        exp_push(0, 0, 32'h5555_AAAA);
        txn(0, 0, 3'b010, 32'h40, 0, 3);

        // Both ports held busy: grants alternate C,D,C,D,C.
        do_reset();
        exp_push(0, 0, 32'hDEAD_BEEF);
        exp_push(1, 0, 32'h11);
        exp_push(0, 0, 32'hDEAD_BEEF);
        exp_push(1, 0, 32'h11);
        exp_push(0, 0, 32'hDEAD_BEEF);
        fork
            begin
                txn(0, 0, 3'b010, 32'h10, 0, 3);
                txn(0, 0, 3'b010, 32'h10, 0, -1);
                txn(0, 0, 3'b010, 32'h10, 0, -1);
            end
            begin
                txn(1, 0, 3'b010, 32'h20, 0, 7);
                txn(1, 0, 3'b010, 32'h20, 0, -1);
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
